kbd_sp_tx: RTL and testbench

//  Amiga keyboard serial transmitter: the sending end of the CIA-A SP/CNT serial link that the CIA SDR shifts in.

---
 rtl/kbd_sp_tx_pkg.sv | 43 ++++
 rtl/kbd_sp_tx_if.sv | 21 ++
 rtl/kbd_sp_tx_timer.sv | 31 +++
 rtl/kbd_sp_tx.sv | 232 +++++++++++++++++++++++
 tb/tb_kbd_sp_tx.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_sp_tx_pkg.sv
// Amiga keyboard serial transmitter: shared types and constants.
// FSM state encoding, power-up stage, fixed keycodes, default timing.
package kbd_sp_tx_pkg;

    typedef enum logic [3:0] {
        ST_RST,
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_WAIT_HS,
        ST_WAIT_REL,
        ST_RS_SETUP,
        ST_RS_LOW,
        ST_RS_HIGH
    } state_t;

    typedef enum logic [1:0] {
        PU_DONE,
        PU_INIT,
        PU_TERM
    } pu_t;

    localparam logic [7:0] KBD_CODE_LOSTSYNC = 8'hF9;
    localparam logic [7:0] KBD_CODE_INIT     = 8'hFD;
    localparam logic [7:0] KBD_CODE_TERM     = 8'hFE;

    localparam int KBD_BIT_CYC_DEF    = 140;
    localparam int KBD_HS_MIN_DEF     = 7;
    localparam int KBD_HS_TIMEOUT_DEF = 1014000;

    // Handshake timeout counter width and synchroniser depth
    localparam int KBD_TO_W     = 20;
    localparam int KBD_SYNC_LAT = 2;

    typedef logic [KBD_TO_W-1:0] to_t;

    // Rotate key-up bit to the end and invert for the active-low line
    function automatic logic [7:0] kbd_shift_word(input logic [7:0] c);
        return ~{c[6:0], c[7]};
    endfunction

endpackage

// File: rtl/kbd_sp_tx_if.sv
// Keycode handshake bundle between the keycode translator and kbd_sp_tx.
// code[7:0] keycode, code_valid offered, code_ready accepted (slave drives).
interface kbd_sp_tx_if;

    logic [7:0] code;
    logic       code_valid;
    logic       code_ready;

    modport master (
        output code,
        output code_valid,
        input  code_ready
    );

    modport slave (
        input  code,
        input  code_valid,
        output code_ready
    );

endinterface

// File: rtl/kbd_sp_tx_timer.sv
// kbd_phase_timer: loadable down-counter advancing on clock-enable ticks.
// Ports: clk, reset, i_en tick, i_load reload, i_load_val, o_done at zero.
module kbd_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (i_load) begin
                r_cnt <= i_load_val;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - W'(1);
            end
        end
    end

    // Loaded with N-1, so a phase lasts exactly N ticks
    assign o_done = i_en & (r_cnt == '0);

endmodule

// File: rtl/kbd_sp_tx.sv
// Amiga keyboard serial transmitter: shifts keycodes out on KDAT/KCLK,
// waits for the host handshake and resynchronises on timeout.
// Ports: clk, reset (async, high), clk7_en tick enable, bus (slave:
// code/code_valid/code_ready), kbd_dat_out/kbd_clk_out open-drain drives
// (0 = pull low), kbd_dat_in sensed KDAT, busy (not IDLE).
// Build option KBD_POWERUP_EN: send 0xFD then 0xFE after reset.
module kbd_sp_tx
    import kbd_sp_tx_pkg::*;
#(
    parameter int BIT_CYC    = KBD_BIT_CYC_DEF,
    parameter int HS_MIN     = KBD_HS_MIN_DEF,
    parameter int HS_TIMEOUT = KBD_HS_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    kbd_sp_tx_if.slave  bus,
    output logic        kbd_dat_out,
    output logic        kbd_clk_out,
    input  logic        kbd_dat_in,
    output logic        busy
);

    localparam int TW = $clog2(BIT_CYC + 1);
    localparam int HW = $clog2(HS_MIN + 1);
    localparam logic [HW-1:0] HS_SAT = HW'(HS_MIN);
    localparam to_t TO_LAST = to_t'(HS_TIMEOUT - 1);
    localparam to_t TO_BLANK = to_t'(KBD_SYNC_LAT);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_code;
    logic [7:0]  w_code_n;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_n;
    logic        r_retry;
    logic        w_retry_n;
    logic        r_sync1;
    logic        r_sync2;
    logic [HW-1:0] r_hs;
    to_t         r_to;
    logic        w_done;
    logic        w_load;
    logic        w_hs_ok;
    logic        w_to;
    logic [7:0]  w_shift;
`ifdef KBD_POWERUP_EN
    pu_t         r_pu;
    pu_t         w_pu_n;
`endif

    assign w_shift = kbd_shift_word(r_code);
    assign w_load  = (w_next != r_state);

    kbd_phase_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_en       (clk7_en),
        .i_load     (w_load),
        .i_load_val (TW'(BIT_CYC - 1)),
        .o_done     (w_done)
    );

    // The first sync'd samples in WAIT_HS still reflect our own last
    // data bit, so low levels are only counted after they have flushed.
    assign w_hs_ok = !r_sync2 && (r_to >= TO_BLANK)
                     && (int'(r_hs) + 1 >= HS_MIN);
    assign w_to    = (r_to == TO_LAST);

    always_comb begin
        w_next    = r_state;
        w_code_n  = r_code;
        w_bit_n   = r_bit;
        w_retry_n = r_retry;
`ifdef KBD_POWERUP_EN
        w_pu_n    = r_pu;
`endif
        unique case (r_state)
            ST_RST: begin
`ifdef KBD_POWERUP_EN
                w_next   = ST_SETUP;
                w_code_n = KBD_CODE_INIT;
                w_bit_n  = 3'd7;
                w_pu_n   = PU_INIT;
`else
                w_next   = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (bus.code_valid) begin
                    w_next   = ST_SETUP;
                    w_code_n = bus.code;
                    w_bit_n  = 3'd7;
                end
            end
            ST_SETUP: begin
                if (w_done) w_next = ST_LOW;
            end
            ST_LOW: begin
                if (w_done) w_next = ST_HIGH;
            end
            ST_HIGH: begin
                if (w_done) begin
                    if (r_bit != 3'd0) begin
                        w_bit_n = r_bit - 3'd1;
                        w_next  = ST_SETUP;
                    end else begin
                        w_next  = ST_WAIT_HS;
                    end
                end
            end
            ST_WAIT_HS: begin
                if (w_hs_ok) begin
                    w_next = ST_WAIT_REL;
                end else if (w_to) begin
                    w_next = ST_RS_SETUP;
                end
            end
            ST_WAIT_REL: begin
                if (r_sync2) begin
                    if (r_retry) begin
                        w_retry_n = 1'b0;
                        w_bit_n   = 3'd7;
                        w_next    = ST_SETUP;
`ifdef KBD_POWERUP_EN
                    end else if (r_pu == PU_INIT) begin
                        w_code_n  = KBD_CODE_TERM;
                        w_bit_n   = 3'd7;
                        w_pu_n    = PU_TERM;
                        w_next    = ST_SETUP;
                    end else begin
                        w_pu_n    = PU_DONE;
                        w_next    = ST_IDLE;
                    end
`else
                    end else begin
                        w_next    = ST_IDLE;
                    end
`endif
                end
            end
            ST_RS_SETUP: begin
                if (w_done) w_next = ST_RS_LOW;
            end
            ST_RS_LOW: begin
                if (w_done) w_next = ST_RS_HIGH;
            end
            ST_RS_HIGH: begin
                if (w_done) begin
                    w_retry_n = 1'b1;
                    w_next    = ST_WAIT_HS;
                end
            end
            default: begin
                w_next = ST_RST;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RST;
            r_code  <= '0;
            r_bit   <= '0;
            r_retry <= 1'b0;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
`ifdef KBD_POWERUP_EN
            r_pu    <= PU_DONE;
`endif
        end else if (clk7_en) begin
            r_state <= w_next;
            r_code  <= w_code_n;
            r_bit   <= w_bit_n;
            r_retry <= w_retry_n;
            r_sync1 <= kbd_dat_in;
            r_sync2 <= r_sync1;
`ifdef KBD_POWERUP_EN
            r_pu    <= w_pu_n;
`endif
        end
    end

    // Handshake low-run and timeout counters, live only in WAIT_HS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to <= '0;
            r_hs <= '0;
        end else if (clk7_en) begin
            if (r_state != ST_WAIT_HS) begin
                r_to <= '0;
                r_hs <= '0;
            end else begin
                if (r_to != '1) r_to <= r_to + to_t'(1);
                if (!r_sync2 && (r_to >= TO_BLANK)) begin
                    if (r_hs != HS_SAT) r_hs <= r_hs + HW'(1);
                end else begin
                    r_hs <= '0;
                end
            end
        end
    end

    always_comb begin
        kbd_dat_out = 1'b1;
        kbd_clk_out = 1'b1;
        unique case (r_state)
            ST_SETUP, ST_HIGH: begin
                kbd_dat_out = w_shift[r_bit];
            end
            ST_LOW: begin
                kbd_dat_out = w_shift[r_bit];
                kbd_clk_out = 1'b0;
            end
            ST_RS_SETUP, ST_RS_HIGH: begin
                kbd_dat_out = 1'b0;
            end
            ST_RS_LOW: begin
                kbd_dat_out = 1'b0;
                kbd_clk_out = 1'b0;
            end
            default: begin
            end
        endcase
    end

    assign bus.code_ready = (r_state == ST_IDLE);
    assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_kbd_sp_tx.sv
// Self-checking bench for kbd_sp_tx: keycode table, handshake, resync,
// mid-frame reset and random codes against a line-bit reference model.
module tb_kbd_sp_tx;

    localparam int BIT_CYC    = 4;
    localparam int HS_MIN     = 2;
    localparam int HS_TIMEOUT = 200;
    localparam int FRAME      = 8 * 3 * BIT_CYC;

    typedef struct {
        logic [7:0] code;
        logic [7:0] line;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clk7_en = 1'b0;
    logic host = 1'b1;
    logic kbd_dat_out;
    logic kbd_clk_out;
    logic kbd_dat_in;
    logic busy;

    int n_chk = 0;
    int n_fail = 0;

    kbd_sp_tx_if bus ();

    assign kbd_dat_in = kbd_dat_out & host;

    kbd_sp_tx #(
        .BIT_CYC    (BIT_CYC),
        .HS_MIN     (HS_MIN),
        .HS_TIMEOUT (HS_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk7_en     (clk7_en),
        .bus         (bus),
        .kbd_dat_out (kbd_dat_out),
        .kbd_clk_out (kbd_clk_out),
        .kbd_dat_in  (kbd_dat_in),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Line bits in send order: original bits 6..0 then 7, inverted
    function automatic logic [7:0] line_bits(input logic [7:0] c);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[7-i] = ~c[(i < 7) ? (6 - i) : 7];
        end
        return r;
    endfunction

    task automatic cap_win(input int n, output logic [7:0] bits,
                           output int falls, output int first_low,
                           output int rdy);
        logic pclk;
        bits = '0;
        falls = 0;
        first_low = -1;
        rdy = 0;
        pclk = kbd_clk_out;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pclk && !kbd_clk_out) begin
                falls++;
                bits = {bits[6:0], kbd_dat_out};
            end
            if (first_low < 0 && !kbd_dat_out) first_low = i;
            if (bus.code_ready) rdy++;
            pclk = kbd_clk_out;
        end
    endtask

    task automatic cap_fixed(input string nm, input logic [7:0] exp);
        logic [7:0] b;
        int f, fl, rs;
        cap_win(FRAME, b, f, fl, rs);
        chk({nm, " falls"}, f, 8);
        chk({nm, " bits"}, b, exp);
        @(negedge clk);
        chk({nm, " wait_hs"},
            {busy, bus.code_ready, kbd_clk_out, kbd_dat_out}, 4'b1011);
    endtask

    task automatic send(input logic [7:0] c);
        int t;
        t = 0;
        bus.code = c;
        bus.code_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.code_ready && t < 50);
        chk("send ready", bus.code_ready, 1);
        @(posedge clk);
        #1 bus.code_valid = 1'b0;
    endtask

    task automatic pulse(input int l);
        repeat (3) @(negedge clk);
        host = 1'b0;
        repeat (l) @(negedge clk);
        host = 1'b1;
    endtask

    task automatic wait_ready(input string nm);
        int t;
        t = 0;
        do begin
            @(posedge clk);
            #1 t++;
        end while (!bus.code_ready && t < 8);
        chk({nm, " ready"}, bus.code_ready, 1);
        chk({nm, " ack latency"}, t <= 3, 1);
        chk({nm, " idle"}, busy, 0);
    endtask

    task automatic chk_resync(input string nm, input int exp_idx);
        logic [7:0] b;
        int f, fl, rs;
        cap_win(230, b, f, fl, rs);
        chk({nm, " rs falls"}, f, 1);
        chk({nm, " rs dat"}, b[0], 0);
        chk({nm, " rs time"}, fl, exp_idx);
        chk({nm, " rs ready"}, rs, 0);
    endtask

    task automatic retx(input string nm, input logic [7:0] exp);
        logic [7:0] b;
        int f, fl, rs;
        pulse(3);
        cap_win(FRAME + 14, b, f, fl, rs);
        chk({nm, " retx falls"}, f, 8);
        chk({nm, " retx bits"}, b, exp);
        chk({nm, " retx ready"}, rs, 0);
        pulse(3);
        wait_ready(nm);
    endtask

    task automatic after_reset();
`ifdef KBD_POWERUP_EN
        logic [7:0] b;
        int f, fl, rs;
        @(posedge clk);
        #1;
        cap_fixed("pu init", line_bits(8'hFD));
        pulse(3);
        cap_win(FRAME + 14, b, f, fl, rs);
        chk("pu term falls", f, 8);
        chk("pu term bits", b, line_bits(8'hFE));
        chk("pu term ready", rs, 0);
        pulse(3);
        wait_ready("pu");
`else
        @(posedge clk);
        #1;
        chk("post reset ready", {bus.code_ready, busy}, 2'b10);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk7_en = 1'b0;
        bus.code_valid = 1'b0;
        host = 1'b1;
        #1;
        chk("reset lines",
            {kbd_dat_out, kbd_clk_out, bus.code_ready, busy}, 4'b1101);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset no tick", {busy, bus.code_ready}, 2'b10);
        clk7_en = 1'b1;
        after_reset();
    endtask

    initial begin
        vec_t tbl[6];
        logic [7:0] rc;
        int l;

        tbl[0] = '{8'h45, 8'h75};
        tbl[1] = '{8'h00, 8'hFF};
        tbl[2] = '{8'hFF, 8'h00};
        tbl[3] = '{8'h80, 8'hFE};
        tbl[4] = '{8'h01, 8'hFD};
        tbl[5] = '{8'hC5, 8'h74};

        bus.code = '0;
        bus.code_valid = 1'b0;
        do_reset();

        foreach (tbl[i]) begin
            send(tbl[i].code);
            cap_fixed($sformatf("tbl%0d", i), tbl[i].line);
            pulse(3);
            wait_ready($sformatf("tbl%0d", i));
        end

        // No handshake at all: resync after the full timeout, then resend
        send(8'h45);
        cap_fixed("nohs", 8'h75);
        chk_resync("nohs", HS_TIMEOUT - 1);
        retx("nohs", 8'h75);

        // One-tick low pulse is too short to count as a handshake
        send(8'h45);
        cap_fixed("short", 8'h75);
        pulse(1);
        chk_resync("short", HS_TIMEOUT - 5);
        retx("short", 8'h75);

        // Reset during the clock-low phase of the fifth bit
        send(8'h45);
        repeat (6 * BIT_CYC + 2 * 3 * BIT_CYC * 1 + 6) @(negedge clk);
        chk("midframe lines", {kbd_clk_out, kbd_dat_out}, 2'b00);
        do_reset();
        send(8'h45);
        cap_fixed("after rst", 8'h75);
        pulse(3);
        wait_ready("after rst");

        for (int r = 0; r < 6; r++) begin
            rc = 8'($urandom);
            l = (r == 0) ? 1 : int'($urandom_range(1, 3));
            send(rc);
            cap_fixed($sformatf("rnd%0d", r), line_bits(rc));
            pulse(l);
            if (l >= HS_MIN) begin
                wait_ready($sformatf("rnd%0d", r));
            end else begin
                chk_resync($sformatf("rnd%0d", r), HS_TIMEOUT - 5);
                retx($sformatf("rnd%0d", r), line_bits(rc));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
